// File: rtl/fir_phase_ctrl.sv
// Polyphase sequencer for the Tx FIR interpolator: runtime oversampling factor, upstream
// valid/ready symbol pull, coefficient-bank select and shift strobe. Optional FIR_CTRL_UNDERRUN_CNT_EN.
module fir_phase_ctrl #(
  parameter int MAX_OS   = 8,
  parameter int NB_PHASE = 3
) (
  input  logic                clk,
  input  logic                i_rst,
  input  logic                i_enable,
  input  logic                i_sync,
  input  logic [NB_PHASE:0]   i_os_factor,
  input  logic                i_sym_valid,
  output logic                o_sym_ready,
  output logic                o_shift,
  output logic [NB_PHASE-1:0] o_phase,
  output logic                o_phase_valid,
  output logic                o_underrun
`ifdef FIR_CTRL_UNDERRUN_CNT_EN
  ,
  output logic [15:0]         o_underrun_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STALL
  } state_t;

  localparam logic [NB_PHASE:0] MAX_N = (NB_PHASE+1)'(MAX_OS);
  localparam logic [NB_PHASE:0] ONE_N = (NB_PHASE+1)'(1);

  state_t              state, state_d;
  logic [NB_PHASE-1:0] phase, phase_d;
  logic [NB_PHASE:0]   n_act, n_act_d;
  logic [NB_PHASE:0]   n_clamp;
  logic [NB_PHASE:0]   last_phase;
  logic                at_last;
  logic                ready;
  logic                xfer;
  logic                shift_d;
  logic                pv_d;
  logic                ur_d;
  logic [15:0]         cnt, cnt_d;

  assign n_clamp    = ((i_os_factor == '0) || (i_os_factor > MAX_N)) ? MAX_N : i_os_factor;
  assign last_phase = n_act - ONE_N;
  assign at_last    = ({1'b0, phase} == last_phase);

  assign ready       = i_enable & ~i_sync & ((state != S_RUN) | at_last);
  assign xfer        = i_sym_valid & ready;
  assign o_sym_ready = ready & ~i_rst;
  assign o_phase     = phase;

  always_comb begin
    state_d = state;
    phase_d = phase;
    n_act_d = n_act;
    shift_d = 1'b0;
    pv_d    = 1'b0;
    ur_d    = 1'b0;
    cnt_d   = cnt;
    if (i_sync) begin
      state_d = S_IDLE;
      phase_d = '0;
      cnt_d   = '0;
    end else if (!i_enable) begin
      // frozen: state, phase and n_act keep their values, strobes drop
    end else if (xfer) begin
      // a transfer always samples the current N, so a new N applies to this very symbol
      state_d = S_RUN;
      phase_d = '0;
      n_act_d = n_clamp;
      shift_d = 1'b1;
      pv_d    = 1'b1;
    end else begin
      unique case (state)
        S_IDLE: begin
          n_act_d = n_clamp;
        end
        S_RUN: begin
          if (!at_last) begin
            phase_d = phase + 1'b1;
            pv_d    = 1'b1;
          end else begin
            state_d = S_STALL;
            phase_d = '0;
            ur_d    = 1'b1;
            if (cnt != '1) cnt_d = cnt + 16'd1;
          end
        end
        S_STALL: begin
          n_act_d = n_clamp;
        end
        default: begin
          state_d = S_IDLE;
          phase_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state         <= S_IDLE;
      phase         <= '0;
      n_act         <= MAX_N;
      o_shift       <= 1'b0;
      o_phase_valid <= 1'b0;
      o_underrun    <= 1'b0;
      cnt           <= '0;
    end else begin
      state         <= state_d;
      phase         <= phase_d;
      n_act         <= n_act_d;
      o_shift       <= shift_d;
      o_phase_valid <= pv_d;
      o_underrun    <= ur_d;
      cnt           <= cnt_d;
    end
  end

`ifdef FIR_CTRL_UNDERRUN_CNT_EN
  assign o_underrun_cnt = cnt;
`else
  logic unused_cnt;
  assign unused_cnt = ^cnt;
`endif

endmodule

// File: tb/tb_fir_phase_ctrl.sv
// Table-driven bench for fir_phase_ctrl: per-cycle input/expected records, registered
// outputs checked through a scoreboard queue one cycle after the stimulus is applied.
module tb_fir_phase_ctrl;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_enable;
  logic       i_sync;
  logic [3:0] i_os_factor;
  logic       i_sym_valid;
  logic       o_sym_ready;
  logic       o_shift;
  logic [2:0] o_phase;
  logic       o_phase_valid;
  logic       o_underrun;
`ifdef FIR_CTRL_UNDERRUN_CNT_EN
  logic [15:0] o_underrun_cnt;
`endif

  fir_phase_ctrl #(.MAX_OS(8), .NB_PHASE(3)) dut (
    .clk           (clk),
    .i_rst         (i_rst),
    .i_enable      (i_enable),
    .i_sync        (i_sync),
    .i_os_factor   (i_os_factor),
    .i_sym_valid   (i_sym_valid),
    .o_sym_ready   (o_sym_ready),
    .o_shift       (o_shift),
    .o_phase       (o_phase),
    .o_phase_valid (o_phase_valid),
    .o_underrun    (o_underrun)
`ifdef FIR_CTRL_UNDERRUN_CNT_EN
    ,
    .o_underrun_cnt(o_underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        sync;
    logic [3:0]  os;
    logic        valid;
    logic        rdy;
    logic        sh;
    logic [2:0]  ph;
    logic        pv;
    logic        ur;
    logic [15:0] cnt;
  } vec_t;

  typedef struct {
    int          idx;
    logic        sh;
    logic [2:0]  ph;
    logic        pv;
    logic        ur;
    logic [15:0] cnt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic sync, input logic [3:0] os, input logic valid,
                     input logic rdy, input logic sh, input logic [2:0] ph, input logic pv,
                     input logic ur, input logic [15:0] cnt);
    vec_t v;
    v.en = en; v.sync = sync; v.os = os; v.valid = valid;
    v.rdy = rdy; v.sh = sh; v.ph = ph; v.pv = pv; v.ur = ur; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic pop_compare();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", -1, 16'd1, 16'd0);
      return;
    end
    e = sb.pop_front();
    check("shift", e.idx, {15'd0, o_shift}, {15'd0, e.sh});
    check("phase", e.idx, {13'd0, o_phase}, {13'd0, e.ph});
    check("phase_valid", e.idx, {15'd0, o_phase_valid}, {15'd0, e.pv});
    check("underrun", e.idx, {15'd0, o_underrun}, {15'd0, e.ur});
`ifdef FIR_CTRL_UNDERRUN_CNT_EN
    check("underrun_cnt", e.idx, o_underrun_cnt, e.cnt);
`endif
  endtask

  initial begin
    exp_t e;
    // N=4 continuous symbols
    add(1,0,4,1, 1,1,0,1,0, 0);
    add(1,0,4,1, 0,0,1,1,0, 0);
    add(1,0,4,1, 0,0,2,1,0, 0);
    add(1,0,4,1, 0,0,3,1,0, 0);
    add(1,0,4,1, 1,1,0,1,0, 0);
    add(1,0,4,1, 0,0,1,1,0, 0);
    add(1,0,4,1, 0,0,2,1,0, 0);
    add(1,0,4,1, 0,0,3,1,0, 0);
    // N 4->2 mid-symbol: current symbol finishes 4 phases
    add(1,0,4,1, 1,1,0,1,0, 0);
    add(1,0,2,1, 0,0,1,1,0, 0);
    add(1,0,2,1, 0,0,2,1,0, 0);
    add(1,0,2,1, 0,0,3,1,0, 0);
    add(1,0,2,1, 1,1,0,1,0, 0);
    add(1,0,2,1, 0,0,1,1,0, 0);
    add(1,0,2,1, 1,1,0,1,0, 0);
    add(1,0,2,1, 0,0,1,1,0, 0);
    add(1,0,2,1, 1,1,0,1,0, 0);
    // back to N=4, then underrun at phase 3 and a 5-cycle gap
    add(1,0,4,1, 0,0,1,1,0, 0);
    add(1,0,4,1, 1,1,0,1,0, 0);
    add(1,0,4,1, 0,0,1,1,0, 0);
    add(1,0,4,1, 0,0,2,1,0, 0);
    add(1,0,4,1, 0,0,3,1,0, 0);
    add(1,0,4,0, 1,0,0,0,1, 1);
    add(1,0,4,0, 1,0,0,0,0, 1);
    add(1,0,4,0, 1,0,0,0,0, 1);
    add(1,0,4,0, 1,0,0,0,0, 1);
    add(1,0,4,0, 1,0,0,0,0, 1);
    add(1,0,4,1, 1,1,0,1,0, 1);
    add(1,0,4,1, 0,0,1,1,0, 1);
    // enable low for 3 cycles at phase 2
    add(1,0,4,1, 0,0,2,1,0, 1);
    add(0,0,4,1, 0,0,2,0,0, 1);
    add(0,0,4,1, 0,0,2,0,0, 1);
    add(0,0,4,1, 0,0,2,0,0, 1);
    add(1,0,4,1, 0,0,3,1,0, 1);
    add(1,0,4,1, 1,1,0,1,0, 1);
    // sync while disabled at phase 2
    add(1,0,4,1, 0,0,1,1,0, 1);
    add(1,0,4,1, 0,0,2,1,0, 1);
    add(0,0,4,1, 0,0,2,0,0, 1);
    add(0,1,4,1, 0,0,0,0,0, 0);
    add(1,0,4,0, 1,0,0,0,0, 0);
    // N=0 and N=9 both clamp to 8
    add(1,0,0,1, 1,1,0,1,0, 0);
    for (int p = 1; p < 8; p++) add(1,0,0,1, 0,0,3'(p),1,0, 0);
    add(1,0,9,1, 1,1,0,1,0, 0);
    for (int p = 1; p < 8; p++) add(1,0,9,1, 0,0,3'(p),1,0, 0);
    // N=1: shift every cycle, underrun as soon as a symbol is missing
    add(1,0,1,1, 1,1,0,1,0, 0);
    add(1,0,1,1, 1,1,0,1,0, 0);
    add(1,0,1,1, 1,1,0,1,0, 0);
    add(1,0,1,0, 1,0,0,0,1, 1);
    // sync beats a pending transfer
    add(1,1,4,1, 0,0,0,0,0, 0);
    add(1,0,4,1, 1,1,0,1,0, 0);

    // reset sequence
    i_rst = 1'b1; i_enable = 1'b1; i_sync = 1'b0; i_os_factor = 4'd4; i_sym_valid = 1'b1;
    @(posedge clk); #1;
    check("ready_in_reset", -1, {15'd0, o_sym_ready}, 16'd0);
    @(posedge clk); #1;
    e.idx = -1; e.sh = 0; e.ph = 0; e.pv = 0; e.ur = 0; e.cnt = 0;
    sb.push_back(e);
    pop_compare();
    i_rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      i_enable    = vecs[i].en;
      i_sync      = vecs[i].sync;
      i_os_factor = vecs[i].os;
      i_sym_valid = vecs[i].valid;
      #1;
      check("sym_ready", i, {15'd0, o_sym_ready}, {15'd0, vecs[i].rdy});
      e.idx = i; e.sh = vecs[i].sh; e.ph = vecs[i].ph; e.pv = vecs[i].pv;
      e.ur = vecs[i].ur; e.cnt = vecs[i].cnt;
      sb.push_back(e);
      @(posedge clk); #1;
      pop_compare();
    end

    // reset in the middle of running returns to the reset state
    i_rst = 1'b1;
    #1;
    check("ready_rst_mid", -2, {15'd0, o_sym_ready}, 16'd0);
    @(posedge clk); #1;
    e.idx = -2; e.sh = 0; e.ph = 0; e.pv = 0; e.ur = 0; e.cnt = 0;
    sb.push_back(e);
    pop_compare();
    i_rst = 1'b0;

    check("sb_drained", -3, 16'(sb.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
